// File: rtl/dport_ext_bridge_pkg.sv
// Shared dport definitions (tag/data/byte-enable widths) and the completion entry payload.
// Optional build macro affecting the bridge: DPORT_EXT_BRIDGE_RANGE_CHECK_EN.
package dport_ext_bridge_pkg;

    localparam int DPORT_TAG_W  = 11;
    localparam int DPORT_DATA_W = 32;
    localparam int DPORT_BE_W   = 4;

    // Payload of one completion entry; the done bit is held separately so it can be reset.
    typedef struct packed {
        logic [DPORT_TAG_W-1:0]  tag;
        logic                    err;
        logic [DPORT_DATA_W-1:0] data;
    } dport_entry_t;

endpackage

// File: rtl/dport_ext_slot_fifo.sv
// Small in-order FIFO of completion-buffer slot indices, one per granted bus request.
module dport_ext_slot_fifo #(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [AW-1:0] data_i,
    input  logic          pop_i,
    output logic [AW-1:0] data_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign empty_o = (r_count == CNT_ZERO);
    assign full_o  = (r_count == CNT_DEPTH);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage needs no reset: reads are gated by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/dport_ext_bridge.sv
// dport responder bridging to an external req/gnt/rvalid bus with an in-order completion buffer.
// Build macro DPORT_EXT_BRIDGE_RANGE_CHECK_EN rejects bus ops outside [EXT_BASE, EXT_BASE+EXT_SIZE).
module dport_ext_bridge
    import dport_ext_bridge_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] EXT_BASE = 32'h0000_0000,
    parameter logic [31:0] EXT_SIZE = 32'h8000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             mem_addr_i,
    input  logic [DPORT_DATA_W-1:0] mem_data_wr_i,
    input  logic                    mem_rd_i,
    input  logic [DPORT_BE_W-1:0]   mem_wr_i,
    input  logic                    mem_cacheable_i,
    input  logic [DPORT_TAG_W-1:0]  mem_req_tag_i,
    input  logic                    mem_invalidate_i,
    input  logic                    mem_writeback_i,
    input  logic                    mem_flush_i,
    output logic [DPORT_DATA_W-1:0] mem_data_rd_o,
    output logic                    mem_accept_o,
    output logic                    mem_ack_o,
    output logic                    mem_error_o,
    output logic [DPORT_TAG_W-1:0]  mem_resp_tag_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [DPORT_BE_W-1:0]   bus_be_o,
    output logic [31:0]             bus_addr_o,
    output logic [DPORT_DATA_W-1:0] bus_wdata_o,
    input  logic                    bus_gnt_i,
    input  logic                    bus_rvalid_i,
    input  logic [DPORT_DATA_W-1:0] bus_rdata_i,
    input  logic                    bus_err_i
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    dport_entry_t             r_entry [DEPTH];
    logic [DEPTH-1:0]         r_done;
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [AW:0]              r_count;
    logic                     r_ack;
    logic                     r_err;
    logic [DPORT_TAG_W-1:0]   r_rtag;
    logic [DPORT_DATA_W-1:0]  r_rdata;

    logic          w_bus_op;
    logic          w_request;
    logic          w_in_range;
    logic          w_bus_issue;
    logic          w_local;
    logic          w_local_err;
    logic          w_full;
    logic          w_push;
    logic          w_fill;
    logic          w_retire;
    logic [AW-1:0] w_slot_head;
    logic          w_slot_empty;
    logic          w_slot_full;
    logic          w_unused;

    assign w_bus_op  = mem_rd_i | (|mem_wr_i);
    assign w_request = w_bus_op | mem_flush_i | mem_invalidate_i | mem_writeback_i;

`ifdef DPORT_EXT_BRIDGE_RANGE_CHECK_EN
    // 33-bit compare so a window ending exactly at 4 GiB does not wrap.
    assign w_in_range = ({1'b0, mem_addr_i} >= {1'b0, EXT_BASE}) &&
                        ({1'b0, mem_addr_i} <  ({1'b0, EXT_BASE} + {1'b0, EXT_SIZE}));
    assign w_unused   = ^{mem_cacheable_i, w_slot_full};
`else
    assign w_in_range = 1'b1;
    assign w_unused   = ^{mem_cacheable_i, w_slot_full, mem_addr_i[1:0], EXT_BASE, EXT_SIZE};
`endif

    assign w_bus_issue = w_bus_op & w_in_range;
    assign w_local     = w_request & ~w_bus_issue;
    assign w_local_err = w_bus_op & ~w_in_range;
    assign w_full      = (r_count == CNT_DEPTH);

    assign bus_req_o    = w_bus_issue & ~w_full;
    assign mem_accept_o = ~w_full & (w_local | bus_gnt_i);
    assign w_push       = w_request & mem_accept_o;
    assign w_fill       = bus_rvalid_i & ~w_slot_empty;
    assign w_retire     = (r_count != CNT_ZERO) & r_done[r_rd_ptr];

    assign bus_we_o    = |mem_wr_i;
    assign bus_be_o    = mem_wr_i;
    assign bus_addr_o  = {mem_addr_i[31:2], 2'b00};
    assign bus_wdata_o = mem_data_wr_i;

    assign mem_ack_o      = r_ack;
    assign mem_error_o    = r_err;
    assign mem_resp_tag_o = r_rtag;
    assign mem_data_rd_o  = r_rdata;

    dport_ext_slot_fifo #(.DEPTH(DEPTH)) u_slot_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push & w_bus_issue),
        .data_i  (r_wr_ptr),
        .pop_i   (bus_rvalid_i),
        .data_o  (w_slot_head),
        .empty_o (w_slot_empty),
        .full_o  (w_slot_full)
    );

    // Control state and registered response; push, fill and retire never hit the same slot.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_done   <= {DEPTH{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= CNT_ZERO;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rtag   <= {DPORT_TAG_W{1'b0}};
            r_rdata  <= {DPORT_DATA_W{1'b0}};
        end else begin
            if (w_push) begin
                r_done[r_wr_ptr] <= w_local;
                r_wr_ptr         <= r_wr_ptr + PTR_ONE;
            end
            if (w_fill) r_done[w_slot_head] <= 1'b1;
            if (w_retire) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_err    <= r_entry[r_rd_ptr].err;
                r_rtag   <= r_entry[r_rd_ptr].tag;
                r_rdata  <= r_entry[r_rd_ptr].data;
            end
            r_ack   <= w_retire;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_retire);
        end
    end

    // Entry payload; validity is tracked by r_done and r_count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_entry[r_wr_ptr].tag  <= mem_req_tag_i;
            r_entry[r_wr_ptr].err  <= w_local_err;
            r_entry[r_wr_ptr].data <= {DPORT_DATA_W{1'b0}};
        end
        if (w_fill) begin
            r_entry[w_slot_head].err  <= bus_err_i;
            r_entry[w_slot_head].data <= bus_rdata_i;
        end
    end

endmodule

// File: tb/tb_dport_ext_bridge.sv
// Scoreboard bench for dport_ext_bridge: randomized dport traffic against a queue-based model.
module tb_dport_ext_bridge;
    localparam int DEPTH = 4;
`ifdef DPORT_EXT_BRIDGE_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef struct { logic [10:0] tag; logic [31:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] data; logic err; int due; } bresp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        rd = 1'b0, cacheable = 1'b0, inv = 1'b0, wb = 1'b0, fl = 1'b0;
    logic [3:0]  wr = 4'h0;
    logic [10:0] tag = 11'h0;
    logic [31:0] rdata_o, bus_addr, bus_wdata, rdata = 32'h0;
    logic        accept, ack, err_o, bus_req, bus_we, gnt = 1'b0, rvalid = 1'b0, berr = 1'b0;
    logic [10:0] rtag;
    logic [3:0]  bus_be;

    exp_t   expq[$];
    bresp_t busq[$];
    int n_checks = 0, n_err = 0;
    int cyc = 0, gnt_mode = 0, n_acc = 0, n_ack = 0, n_txn = 0;
    int last_rv_cyc = 0, last_ack_cyc = 0, last_acc_cyc = 0;
    bit hold_rv = 1'b0, force_en = 1'b0, force_err = 1'b0;
    logic [31:0] force_data = 32'h0;
    int force_lat = 1;

    dport_ext_bridge #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_n), .mem_addr_i(addr), .mem_data_wr_i(wdata),
        .mem_rd_i(rd), .mem_wr_i(wr), .mem_cacheable_i(cacheable), .mem_req_tag_i(tag),
        .mem_invalidate_i(inv), .mem_writeback_i(wb), .mem_flush_i(fl),
        .mem_data_rd_o(rdata_o), .mem_accept_o(accept), .mem_ack_o(ack),
        .mem_error_o(err_o), .mem_resp_tag_o(rtag), .bus_req_o(bus_req), .bus_we_o(bus_we),
        .bus_be_o(bus_be), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_gnt_i(gnt),
        .bus_rvalid_i(rvalid), .bus_rdata_i(rdata), .bus_err_i(berr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return !RANGE_EN || (a < 32'h8000_0000);
    endfunction

    // Bus target: grant policy plus in-order responses once their due cycle arrives.
    always @(posedge clk) begin
        #1;
        case (gnt_mode)
            0:       gnt = 1'b0;
            1:       gnt = 1'b1;
            default: gnt = ($urandom_range(0, 9) < 7);
        endcase
        if (!hold_rv && busq.size() > 0 && busq[0].due <= cyc) begin
            rvalid = 1'b1; rdata = busq[0].data; berr = busq[0].err;
            void'(busq.pop_front());
            last_rv_cyc = cyc;
        end else begin
            rvalid = 1'b0; rdata = $urandom; berr = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) if (bus_req && gnt) n_txn++;

    // Stimulus side: every accepted request pushes its expected response.
    always @(negedge clk) begin
        if (rst_n && accept && (rd || (|wr) || fl || inv || wb)) begin
            exp_t e; bresp_t b; bit busop;
            busop = (rd || (|wr)) && in_window(addr);
            n_acc++; last_acc_cyc = cyc;
            e.tag = tag;
            if (busop) begin
                check("bus_req_at_accept", bus_req, 1'b1);
                check("bus_we", bus_we, |wr);
                check("bus_be", bus_be, wr);
                check("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
                check("bus_wdata", bus_wdata, wdata);
                b.data = force_en ? force_data : $urandom;
                b.err  = force_en ? force_err : ($urandom_range(0, 7) == 0);
                b.due  = cyc + (force_en ? force_lat : $urandom_range(1, 5));
                force_en = 1'b0;
                busq.push_back(b);
                e.data = b.data; e.err = b.err;
            end else begin
                check("no_bus_req_local", bus_req, 1'b0);
                e.data = 32'h0; e.err = rd || (|wr);
            end
            expq.push_back(e);
        end
    end

    // Monitor: compare every ack against the head of the expected queue.
    always @(negedge clk) begin
        if (ack) begin
            n_ack++; last_ack_cyc = cyc;
            if (expq.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL unexpected_ack: tag %h with nothing pending", rtag);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("ack_tag", rtag, e.tag);
                check("ack_data", rdata_o, e.data);
                check("ack_err", err_o, e.err);
            end
        end
    end

    task automatic set_req(input logic r, input logic [3:0] w, input logic [2:0] m,
                           input logic [10:0] t, input logic [31:0] a, input logic [31:0] d);
        rd = r; wr = w; fl = m[0]; inv = m[1]; wb = m[2]; tag = t; addr = a; wdata = d;
        cacheable = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Hold a request until accepted (bounded); entered and left at posedge+2.
    task automatic issue(input logic r, input logic [3:0] w, input logic [2:0] m,
                         input logic [10:0] t, input logic [31:0] a, input logic [31:0] d,
                         input int budget);
        bit ok = 1'b0;
        set_req(r, w, m, t, a, d);
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (accept) ok = 1'b1;
        end
        check("accept_within_budget", ok, 1'b1);
        @(posedge clk); #2;
        set_req(1'b0, 4'h0, 3'h0, 11'h0, 32'h0, 32'h0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && expq.size() != 0; i++) idle(1);
        check("drain_empty", expq.size(), 32'd0);
        idle(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r, kind, idl;
        bit got;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ack", ack, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_tag", rtag, 11'h0);
        check("rst_data", rdata_o, 32'h0);
        check("rst_bus_req", bus_req, 1'b0);
        rst_n = 1'b1;
        idle(1);
        check("idle_accept_no_gnt", accept, 1'b0);

        // Single read, fixed latency
        gnt_mode = 1; idle(1);
        a0 = n_ack;
        force_en = 1'b1; force_data = 32'hDEAD_BEEF; force_err = 1'b0; force_lat = 3;
        issue(1'b1, 4'h0, 3'h0, 11'h005, 32'h0000_0100, 32'h0, 20);
        drain(50);
        check("single_read_acks", n_ack - a0, 32'd1);
        check("read_rvalid_to_ack", last_ack_cyc - last_rv_cyc, 32'd2);

        // Write (slow), flush, read: in-order acks, two bus transactions
        a0 = n_txn;
        force_en = 1'b1; force_data = 32'h0BAD_F00D; force_err = 1'b0; force_lat = 5;
        issue(1'b0, 4'b0011, 3'h0, 11'h001, 32'h0000_0202, 32'hA5A5_0001, 20);
        issue(1'b0, 4'h0, 3'b001, 11'h002, 32'h0, 32'h0, 20);
        issue(1'b1, 4'h0, 3'h0, 11'h003, 32'h0000_0204, 32'h0, 20);
        drain(50);
        check("mix_bus_txns", n_txn - a0, 32'd2);

        // Local op into empty buffer
        issue(1'b0, 4'h0, 3'b010, 11'h010, 32'h0, 32'h0, 20);
        drain(20);
        check("local_accept_to_ack", last_ack_cyc - last_acc_cyc, 32'd2);

        // Backpressure: responses withheld
        hold_rv = 1'b1; a0 = n_acc;
        set_req(1'b1, 4'h0, 3'h0, 11'h020, 32'h0000_0300, 32'h0);
        repeat (10) @(negedge clk);
        check("bp_accepts", n_acc - a0, 32'd4);
        check("bp_accept_low", accept, 1'b0);
        @(posedge clk); #2;
        hold_rv = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rvalid) got = 1'b1;
        end
        r = cyc;
        check("bp_rvalid_seen", got, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (accept) got = 1'b1;
            else @(negedge clk);
        end
        check("bp_reaccepted", got, 1'b1);
        check("bp_reaccept_delay", cyc - r, 32'd2);
        @(posedge clk); #2;
        set_req(1'b0, 4'h0, 3'h0, 11'h0, 32'h0, 32'h0);
        drain(100);

        // No grant
        gnt_mode = 0; idle(1);
        a0 = n_ack;
        set_req(1'b1, 4'h0, 3'h0, 11'h030, 32'h0000_0400, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("nogrant_accept", accept, 1'b0);
            check("nogrant_bus_req", bus_req, 1'b1);
        end
        check("nogrant_no_ack", n_ack - a0, 32'd0);
        gnt_mode = 1;
        @(posedge clk); #2;
        issue(1'b1, 4'h0, 3'h0, 11'h030, 32'h0000_0400, 32'h0, 20);
        drain(50);

        // Bus error
        force_en = 1'b1; force_data = 32'h1234_5678; force_err = 1'b1; force_lat = 2;
        issue(1'b1, 4'h0, 3'h0, 11'h7FF, 32'h0000_0500, 32'h0, 20);
        drain(50);

        // Reset with three reads outstanding
        hold_rv = 1'b1;
        issue(1'b1, 4'h0, 3'h0, 11'h041, 32'h0000_0600, 32'h0, 20);
        issue(1'b1, 4'h0, 3'h0, 11'h042, 32'h0000_0604, 32'h0, 20);
        issue(1'b1, 4'h0, 3'h0, 11'h043, 32'h0000_0608, 32'h0, 20);
        rst_n = 1'b0;
        expq.delete(); busq.delete();
        a0 = n_ack;
        @(posedge clk); #2;
        rst_n = 1'b1; hold_rv = 1'b0;
        check("post_reset_accept", accept, 1'b1);
        check("post_reset_ack", ack, 1'b0);
        idle(6);
        check("post_reset_no_acks", n_ack - a0, 32'd0);
        issue(1'b1, 4'h0, 3'h0, 11'h044, 32'h0000_0700, 32'h0, 20);
        drain(50);
        check("post_reset_read_acked", n_ack - a0, 32'd1);

`ifdef DPORT_EXT_BRIDGE_RANGE_CHECK_EN
        // Out-of-window read completes locally with error
        issue(1'b1, 4'h0, 3'h0, 11'h055, 32'h9000_0000, 32'h0, 20);
        drain(20);
        check("range_err_latency", last_ack_cyc - last_acc_cyc, 32'd2);
`endif

        // Randomized mix
        gnt_mode = 2;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 7);
            if (kind < 4)
                issue(1'b1, 4'h0, 3'h0, 11'($urandom), $urandom, $urandom, 300);
            else if (kind < 6)
                issue(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 3'h0,
                      11'($urandom), $urandom, $urandom, 300);
            else
                issue(1'b0, 4'h0, 3'($urandom_range(1, 7)), 11'($urandom), $urandom, $urandom, 300);
            idl = $urandom_range(0, 2);
            if (idl > 0) idle(idl);
        end
        drain(2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dport_ext_bridge.md
Name: dport_ext_bridge

Overview:
- Responder (target) end of the core data-port (dport) request/accept/ack/tag interface.
- Converts dport requests into a simple external memory bus with req/gnt issue and in-order rvalid responses of variable latency.
- Tracks up to DEPTH outstanding requests in an in-order completion buffer and returns ack, data, error and tag to the dport initiator.
- Cache-maintenance-only requests (flush/invalidate/writeback) complete locally in order, without a bus transaction.

Parameters:
- DEPTH, 4: completion buffer entries; power of two, 2..8.
- EXT_BASE, 32'h00000000: base of the legal external window (used only with the optional feature).
- EXT_SIZE, 32'h80000000: size of the legal external window in bytes (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- mem_addr_i  in  32  request address
- mem_data_wr_i  in  32  write data
- mem_rd_i  in  1  read request
- mem_wr_i  in  4  byte write enables
- mem_cacheable_i  in  1  ignored
- mem_req_tag_i  in  11  request tag
- mem_invalidate_i / mem_writeback_i / mem_flush_i  in  1 each  maintenance ops
- mem_data_rd_o  out  32  response data
- mem_accept_o  out  1  request accepted this cycle
- mem_ack_o  out  1  response valid, single-cycle pulse
- mem_error_o  out  1  response error
- mem_resp_tag_o  out  11  response tag
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_be_o  out  4  byte enables
- bus_addr_o  out  32  word address: mem_addr_i with [1:0] forced to 0
- bus_wdata_o  out  32  write data
- bus_gnt_i  in  1  bus grant
- bus_rvalid_i  in  1  bus response valid; exactly one per grant, in order
- bus_rdata_i  in  32  bus read data
- bus_err_i  in  1  bus error, qualified by bus_rvalid_i

Behaviour:
- Request decode:
  - request = rd | (|wr) | flush | invalidate | writeback.
  - bus op = rd | (|wr); write when |wr, otherwise read. Write wins if rd and wr are both set.
  - local op = request & !bus op.
- Issue and accept:
  - full = (count == DEPTH), using the count before any same-cycle pop.
  - bus_req_o = bus op & !full.
  - mem_accept_o = !full & (local op | bus_gnt_i).
  - Push on request & mem_accept_o. Pass-through outputs are combinational from the dport inputs.
- Buffer entry contents: tag, done, err, data.
  - Local entries are pushed with done=1, err=0, data=0.
  - Bus entries are pushed with done=0, and their slot index is pushed into a slot FIFO.
- Bus response handling:
  - On bus_rvalid_i, the slot FIFO head identifies the entry. Set its done=1, data=bus_rdata_i, err=bus_err_i, then pop the slot FIFO.
  - An rvalid with the slot FIFO empty is ignored.
- Retire:
  - When the head entry is done (registered state), pop it and register the response on the next edge:
    - mem_ack_o = 1
    - mem_resp_tag_o = entry tag
    - mem_data_rd_o = entry data
    - mem_error_o = entry err
  - At most one retire per cycle.
- Latency:
  - rvalid at cycle N for the head entry → mem_ack_o at cycle N+2.
  - Local op accepted at N into an empty buffer → ack at N+2.
- Ordering: responses are strictly in acceptance order, including locals queued behind pending bus entries.
- Simultaneous events: push, rvalid fill and retire can all happen in the same cycle. count = count + push - pop.
- Pointers: power-of-two wrap, log2(DEPTH) bits; count is log2(DEPTH)+1 bits.
- Reset (any time, including mid-operation): clear pointers, count, done bits and slot FIFO. mem_ack_o, mem_error_o, mem_data_rd_o and mem_resp_tag_o are reset to 0. In-flight bus responses are dropped; the bus target shares the reset.

Optional Feature:
- Macro: DPORT_EXT_BRIDGE_RANGE_CHECK_EN.
- Defined: a bus op whose address is outside [EXT_BASE, EXT_BASE+EXT_SIZE) is not issued; bus_req_o=0.
  - It is accepted when !full and pushed as a local entry with err=1, data=0.
  - It is acked in order with mem_error_o=1.
- Undefined: all bus ops are issued. EXT_BASE and EXT_SIZE are unused.

Decomposition:
- Shared include dport_defs:
  - DPORT_TAG_W=11, DPORT_DATA_W=32, DPORT_BE_W=4.
  - Completion entry field widths.
- One sub-module: dport_ext_slot_fifo.
  - Parameterised DEPTH x log2(DEPTH) synchronous FIFO with push/pop/empty/full.
  - Holds the slot indices of granted bus entries.

Test Plan:
- Single read: addr 0x100, tag 0x05, gnt same cycle, rvalid 3 cycles later with data 0xDEADBEEF → one ack 2 cycles after rvalid, data 0xDEADBEEF, tag 0x05, error 0.
- Write plus maintenance mix: write tag 1 (be 4'b0011), then flush tag 2, then read tag 3 (bus delays write response 5 cycles) → acks in order 1,2,3; flush ack not before write ack; bus sees only 2 transactions.
- Backpressure: DEPTH=4, gnt always 1, rvalid withheld → exactly 4 accepts, accept low thereafter; the first rvalid re-enables accept within 2 cycles.
- No grant: bus_gnt_i=0 for 10 cycles with a read pending → mem_accept_o=0 and bus_req_o=1 throughout, no ack.
- Bus error: read tag 0x7FF, rvalid with bus_err_i=1 and data 0x12345678 → ack with error 1, tag 0x7FF, data 0x12345678.
- Reset mid-flight: 3 outstanding reads, assert rst_i low for 1 cycle → count 0, no acks, accept high; a later read completes normally. With the macro: read at 0x90000000 (EXT_SIZE=0x80000000) → no bus_req_o, ack error 1 at N+2.
